// File: rtl/blinky_pkg.sv
// Shared types for the blinky LED path: display modes and scheduler states.
package blinky_pkg;

  localparam int unsigned MODE_NUM = 4;

  typedef enum logic [1:0] {
    COUNT = 2'd0,
    SCAN  = 2'd1,
    BLINK = 2'd2,
    HOLD  = 2'd3
  } mode_t;

  typedef enum logic {
    RUN    = 1'b0,
    SWITCH = 1'b1
  } sched_state_t;

  // Cyclic successor; HOLD wraps back to COUNT.
  function automatic mode_t next_mode(input mode_t m);
    logic [1:0] nxt;
    nxt = 2'(m) + 2'd1;
    return mode_t'(nxt);
  endfunction

endpackage

// File: rtl/led_mode_sched_scan.sv
// Bouncing one-hot position for the SCAN pattern.
module led_scan_gen #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             restart,
  input  logic             step,
  output logic [WIDTH-1:0] vec
);

  localparam int unsigned PW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [PW-1:0] LAST = PW'(WIDTH - 1);

  logic [PW-1:0] pos_q;
  logic          up_q;

  always_ff @(posedge clk) begin
    if (rst || restart) begin
      pos_q <= '0;
      up_q  <= 1'b1;
    end else if (step) begin
      if (up_q) begin
        if (pos_q == LAST) begin
          pos_q <= pos_q - PW'(1);
          up_q  <= 1'b0;
        end else begin
          pos_q <= pos_q + PW'(1);
        end
      end else begin
        if (pos_q == '0) begin
          pos_q <= pos_q + PW'(1);
          up_q  <= 1'b1;
        end else begin
          pos_q <= pos_q - PW'(1);
        end
      end
    end
  end

  always_comb begin
    vec = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (PW'(i) == pos_q) vec[i] = 1'b1;
    end
  end

endmodule

// File: rtl/led_mode_sched.sv
// LED pattern scheduler: selects one of four patterns, switching on request or
// after a dwell of ticks, always through a one-cycle blank state.
module led_mode_sched
  import blinky_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned DWELL_TICKS = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic [WIDTH-1:0] count,
  input  logic             auto_en,
  input  logic             req_valid,
  input  logic [1:0]       req_mode,
  output logic             req_ready,
  output logic [1:0]       mode,
  output logic             mode_changed,
  output logic [WIDTH-1:0] leds
);

  localparam int unsigned DW = (DWELL_TICKS > 1) ? $clog2(DWELL_TICKS) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_TICKS - 1);

  sched_state_t     state_q;
  mode_t            mode_q;
  mode_t            pend_q;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] capture_q;
  logic [DW-1:0]    dwell_q;
  logic             blink_q;
  logic             mode_changed_q;
  logic [WIDTH-1:0] scan_vec;

  logic accept;
  logic advance;
  logic leave;
  logic step;

  always_comb begin
    accept  = req_valid && (state_q == RUN);
    advance = auto_en && tick && (dwell_q == DWELL_LAST) && (state_q == RUN);
    leave   = accept || advance;
    // A tick coinciding with a switch must not step the pattern.
    step    = tick && (state_q == RUN) && !leave;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= RUN;
      mode_q         <= COUNT;
      pend_q         <= COUNT;
      count_q        <= '0;
      capture_q      <= '0;
      dwell_q        <= '0;
      blink_q        <= 1'b1;
      mode_changed_q <= 1'b0;
    end else begin
      count_q        <= count;
      mode_changed_q <= 1'b0;
      if (state_q == SWITCH) begin
        state_q        <= RUN;
        mode_q         <= pend_q;
        blink_q        <= 1'b1;
        mode_changed_q <= 1'b1;
      end else if (leave) begin
        state_q   <= SWITCH;
        pend_q    <= accept ? mode_t'(req_mode) : next_mode(mode_q);
        capture_q <= leds;
        dwell_q   <= '0;
      end else begin
        if (auto_en && tick) dwell_q <= dwell_q + DW'(1);
        if (step && mode_q == BLINK) blink_q <= ~blink_q;
      end
    end
  end

  led_scan_gen #(
    .WIDTH(WIDTH)
  ) u_scan (
    .clk    (clk),
    .rst    (rst),
    .restart(state_q == SWITCH),
    .step   (step && (mode_q == SCAN)),
    .vec    (scan_vec)
  );

  // Output select is driven purely by registers, so leds changes only at edges.
  always_comb begin
    leds = '0;
    if (state_q == RUN) begin
      unique case (mode_q)
        COUNT:   leds = count_q;
        SCAN:    leds = scan_vec;
        BLINK:   leds = {WIDTH{blink_q}};
        HOLD:    leds = capture_q;
        default: leds = '0;
      endcase
    end
  end

  assign req_ready    = (state_q == RUN);
  assign mode         = 2'(mode_q);
  assign mode_changed = mode_changed_q;

endmodule
